// File: rtl/song_seq_pkg.sv
// Shared definitions for the song sequencer: FSM state encoding and the
// end-of-song marker value used in the ROM word stream.
package song_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LATCH,
      ST_ADVANCE,
      ST_REST,
      ST_DONE
   } state_t;

   // ROM words are {is_rest, note, duration, metadata}; an all-zero word ends a song.
   localparam int END_MARKER = 0;

endpackage

// File: rtl/rest_timer.sv
// Beat counter for rests: counts enabled ticks and reports when the count
// reaches the latched rest length.
module rest_timer #(
   parameter int DUR_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             load,
   input  logic [DUR_W-1:0] target,
   input  logic             tick,
   output logic             done
);

   logic [DUR_W-1:0] count_reg;
   logic [DUR_W-1:0] target_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg  <= '0;
         target_reg <= '0;
      end else begin
         if (load) begin
            target_reg <= target;
         end
         if (clr) begin
            count_reg <= '0;
         end else if (tick) begin
            count_reg <= count_reg + {{(DUR_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign done = (count_reg == target_reg);

endmodule

// File: rtl/song_sequencer.sv
// Walks a selected song in an external 1-cycle-latency ROM, issuing note
// events and timing rests on the beat tick, with pause, loop and song change.
module song_sequencer
   import song_seq_pkg::*;
#(
   parameter int SONG_W = 4,
   parameter int ADDR_W = 5,
   parameter int NOTE_W = 6,
   parameter int DUR_W  = 6,
   parameter int META_W = 3
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             play,
   input  logic                             loop,
   input  logic [SONG_W-1:0]                song,
   input  logic                             beat,
   output logic [SONG_W+ADDR_W-1:0]         rom_addr,
   input  logic [NOTE_W+DUR_W+META_W:0]     rom_data,
   output logic                             new_note,
   output logic [NOTE_W-1:0]                note,
   output logic [DUR_W-1:0]                 duration,
   output logic [META_W-1:0]                metadata,
   output logic                             song_done
);

   localparam int WORD_W   = 1 + NOTE_W + DUR_W + META_W;
   localparam int DUR_LSB  = META_W;
   localparam int NOTE_LSB = META_W + DUR_W;
   localparam int REST_BIT = WORD_W - 1;
   localparam logic [ADDR_W-1:0] IDX_MAX = '1;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   idx_reg, idx_next;
   logic [SONG_W-1:0]   song_q_reg, song_q_next;
   logic [NOTE_W-1:0]   note_reg, note_next;
   logic [DUR_W-1:0]    duration_reg, duration_next;
   logic [META_W-1:0]   metadata_reg, metadata_next;
   logic                new_note_reg, new_note_next;
   logic                song_done_reg, song_done_next;
   logic                loop_q_reg;

   logic                rest_field;
   logic [NOTE_W-1:0]   note_field;
   logic [DUR_W-1:0]    duration_field;
   logic [META_W-1:0]   metadata_field;
   logic                timer_clr, timer_load, timer_tick, rest_done;
   logic                end_of_song;

   assign rest_field     = rom_data[REST_BIT];
   assign note_field     = rom_data[NOTE_LSB +: NOTE_W];
   assign duration_field = rom_data[DUR_LSB +: DUR_W];
   assign metadata_field = rom_data[0 +: META_W];

   rest_timer #(
      .DUR_W (DUR_W)
   ) u_rest_timer (
      .clk    (clk),
      .reset  (reset),
      .clr    (timer_clr),
      .load   (timer_load),
      .target (duration_field),
      .tick   (timer_tick),
      .done   (rest_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         idx_reg       <= '0;
         song_q_reg    <= '0;
         note_reg      <= '0;
         duration_reg  <= '0;
         metadata_reg  <= '0;
         new_note_reg  <= 1'b0;
         song_done_reg <= 1'b0;
         loop_q_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         song_q_reg    <= song_q_next;
         note_reg      <= note_next;
         duration_reg  <= duration_next;
         metadata_reg  <= metadata_next;
         new_note_reg  <= new_note_next;
         song_done_reg <= song_done_next;
         loop_q_reg    <= loop;
      end
   end

   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      song_q_next    = song_q_reg;
      note_next      = note_reg;
      duration_next  = duration_reg;
      metadata_next  = metadata_reg;
      new_note_next  = 1'b0;
      song_done_next = 1'b0;
      timer_clr      = 1'b0;
      timer_load     = 1'b0;
      timer_tick     = 1'b0;
      end_of_song    = 1'b0;

      // A song change overrides pause, rests and the finished state alike.
      if ((state_reg != ST_IDLE) && (song != song_q_reg)) begin
         state_next  = ST_FETCH;
         idx_next    = '0;
         song_q_next = song;
         timer_clr   = 1'b1;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (play) begin
                  state_next  = ST_FETCH;
                  song_q_next = song;
                  idx_next    = '0;
               end
            end
            ST_FETCH: begin
               if (play) begin
                  state_next = ST_LATCH;
               end
            end
            ST_LATCH: begin
               // Pausing here drops the fetched word; resume re-reads it.
               if (!play) begin
                  state_next = ST_FETCH;
               end else if (rom_data == WORD_W'(END_MARKER)) begin
                  end_of_song = 1'b1;
               end else if (!rest_field) begin
                  new_note_next = 1'b1;
                  note_next     = note_field;
                  duration_next = duration_field;
                  metadata_next = metadata_field;
                  state_next    = ST_ADVANCE;
               end else begin
                  timer_clr  = 1'b1;
                  timer_load = 1'b1;
                  state_next = (duration_field == '0) ? ST_ADVANCE : ST_REST;
               end
            end
            ST_REST: begin
               if (play) begin
                  if (rest_done) begin
                     timer_clr  = 1'b1;
                     state_next = ST_ADVANCE;
                  end else begin
                     timer_tick = beat;
                  end
               end
            end
            ST_ADVANCE: begin
               if (play) begin
                  if (idx_reg == IDX_MAX) begin
                     end_of_song = 1'b1;
                  end else begin
                     idx_next   = idx_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
                     state_next = ST_FETCH;
                  end
               end
            end
            ST_DONE: begin
               song_done_next = 1'b1;
               if (loop && !loop_q_reg) begin
                  state_next     = ST_FETCH;
                  idx_next       = '0;
                  song_done_next = 1'b0;
               end
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase

         if (end_of_song) begin
            song_done_next = 1'b1;
            if (loop) begin
               state_next = ST_FETCH;
               idx_next   = '0;
            end else begin
               state_next = ST_DONE;
            end
         end
      end
   end

   assign rom_addr  = {song_q_reg, idx_reg};
   assign new_note  = new_note_reg;
   assign note      = note_reg;
   assign duration  = duration_reg;
   assign metadata  = metadata_reg;
   assign song_done = song_done_reg;

endmodule
